oe_strobe_monitor: RTL

- Receiving end of the OE strobe interface: observes an output-enable strobe line (one-tick-wide pulses, fixed spacing, finite burst) and checks it against the expected pattern.
- Counts pulses, measures the spacing between rising edges in TICK units, and reports burst completion or the first protocol violation.
- Sits on the fabric side as a hardware self-check for the strobe generator, for the bench and for board bring-up.

---
 rtl/oe_strobe_monitor_pkg.sv | 34 +++
 rtl/oe_strobe_monitor_sync.sv | 36 +++
 rtl/oe_strobe_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/oe_strobe_monitor_pkg.sv
// Shared types and defaults for the OE strobe generator/monitor pair.
// Keeping the burst defaults here keeps both ends of the link consistent.
package oe_strobe_monitor_pkg;

  localparam int unsigned DEF_EXP_PERIOD = 16;
  localparam int unsigned DEF_BURST_LEN  = 4;
  localparam int unsigned DEF_TIMEOUT    = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE,
    POST,
    DONE_S,
    ERR_S
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PERIOD  = 2'd1,
    ERR_MISSING = 2'd2,
    ERR_EXTRA   = 2'd3
  } err_code_e;

  // True when a measured spacing is within +/-tol of the expected spacing.
  function automatic logic in_tol(input int unsigned interval,
                                  input int unsigned expected,
                                  input int unsigned tol);
    int unsigned diff;
    diff = (interval > expected) ? interval - expected : expected - interval;
    return diff <= tol;
  endfunction

endpackage

// File: rtl/oe_strobe_monitor_sync.sv
// sync_edge_detect: 2-FF synchronizer plus registered rising-edge pulse.
// The pulse appears three clock edges after the asynchronous input rises.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_out
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[0], sig_in};
    prev_d = sync_q[1];
    edge_d = sync_q[1] & ~prev_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/oe_strobe_monitor.sv
// Receive-side checker for the OE strobe: counts pulses, measures edge
// spacing in TICK units and flags burst completion or the first violation.
module oe_strobe_monitor
  import oe_strobe_monitor_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = 0,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          oe_in,
  input  logic          arm,
  output logic [7:0]    pulse_cnt,
  output logic [CW-1:0] last_period,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pulse_cnt_q, pulse_cnt_d;
  logic [CW-1:0] last_period_q, last_period_d;
  err_code_e     err_code_q, err_code_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          oe_edge;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    pulse_next;
  logic          timeout_hit;
  logic          period_ok;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (oe_in),
    .edge_out (oe_edge)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    // The captured interval includes a TICK landing on the edge cycle itself.
    cnt_inc       = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    pulse_next    = pulse_cnt_q + 8'd1;
    timeout_hit   = (cnt_inc >= CW'(TIMEOUT));
    period_ok     = in_tol(32'(cnt_inc), EXP_PERIOD, TOL);

    state_d       = state_q;
    cnt_d         = cnt_inc;
    pulse_cnt_d   = pulse_cnt_q;
    last_period_d = last_period_q;
    err_code_d    = err_code_q;

    if (arm) begin
      // A restart request outranks any edge arriving in the same cycle.
      state_d       = WAIT_FIRST;
      cnt_d         = '0;
      pulse_cnt_d   = '0;
      last_period_d = '0;
      err_code_d    = ERR_NONE;
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (oe_edge) begin
            pulse_cnt_d = 8'd1;
            cnt_d       = '0;
            state_d     = (BURST_LEN == 1) ? POST : MEASURE;
          end
        end
        MEASURE: begin
          if (oe_edge) begin
            last_period_d = cnt_inc;
            cnt_d         = '0;
            if (!period_ok) begin
              err_code_d = ERR_PERIOD;
              state_d    = ERR_S;
            end else begin
              pulse_cnt_d = pulse_next;
              if (pulse_next == 8'(BURST_LEN)) state_d = POST;
            end
          end else if (timeout_hit) begin
            err_code_d = ERR_MISSING;
            state_d    = ERR_S;
          end
        end
        POST: begin
          if (oe_edge) begin
            err_code_d    = ERR_EXTRA;
            last_period_d = cnt_inc;
            state_d       = ERR_S;
          end else if (timeout_hit) begin
            state_d = DONE_S;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == WAIT_FIRST) || (state_d == MEASURE) || (state_d == POST);
    done_d = (state_d == DONE_S);
    err_d  = (state_d == ERR_S);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pulse_cnt_q   <= '0;
      last_period_q <= '0;
      err_code_q    <= ERR_NONE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      last_period_q <= last_period_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign pulse_cnt   = pulse_cnt_q;
  assign last_period = last_period_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
